// File: rtl/lpf_sample_strober_if.sv
// Sample/strobe bus between the boxcar decimator and the slow-channel low-pass filter.
// The master drives raw samples and observes the averaged sample and strobe; the slave is the strober.
interface lpf_sample_strober_if;
  logic               enable;
  logic signed [15:0] din;
  logic               din_valid;
  logic signed [15:0] x;
  logic               strobe;
  logic [7:0]         overrun_cnt;
  logic               busy;

  modport master (
    output enable, din, din_valid,
    input  x, strobe, overrun_cnt, busy
  );

  modport slave (
    input  enable, din, din_valid,
    output x, strobe, overrun_cnt, busy
  );
endinterface

// File: rtl/lpf_sample_strober.sv
// Boxcar-averages 2^DECIM_LOG2 raw samples and strobes each average into the low-pass filter,
// keeping strobe rising edges at least MIN_GAP cycles apart. Define LPF_STROBER_ROUND_EN for round-half-up averages.
module lpf_sample_strober #(
  parameter int DECIM_LOG2 = 4,
  parameter int STB_WIDTH  = 2,
  parameter int MIN_GAP    = 3
) (
  input logic                 lb_clk,
  input logic                 reset_n,
  lpf_sample_strober_if.slave strober_io
);

  localparam int ACC_W   = 17 + DECIM_LOG2;
  localparam int CNT_W   = DECIM_LOG2 + 1;
  localparam int NSAMP   = 1 << DECIM_LOG2;
  localparam int GAP_LEN = MIN_GAP - STB_WIDTH;
  localparam int TMR_W   = $clog2(MIN_GAP + 1);

`ifdef LPF_STROBER_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(NSAMP >> 1);
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NSAMP - 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(STB_WIDTH - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] sum_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    pend_q;
  logic [15:0]             pend_val_q;
  logic [15:0]             result_d;
  logic [15:0]             x_q;
  logic                    strobe_q;
  logic [7:0]              ovr_q;
  logic [TMR_W-1:0]        tmr_q;
  logic                    accept;
  logic                    last_d;
  logic                    consume;

  always_comb begin
    accept   = strober_io.enable & strober_io.din_valid;
    sum_d    = acc_q + {{(ACC_W-16){strober_io.din[15]}}, strober_io.din};
    result_d = 16'((sum_d + RND) >>> DECIM_LOG2);
    last_d   = accept && (cnt_q == LAST_CNT);
    // The FSM takes the pending value from IDLE or on the last GAP edge.
    consume  = strober_io.enable && pend_q &&
               ((state_q == IDLE) || ((state_q == GAP) && (tmr_q == '0)));
    if (!strober_io.enable || last_d) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = sum_d;
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge lb_clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      x_q        <= '0;
      strobe_q   <= 1'b0;
      ovr_q      <= '0;
      tmr_q      <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;

      if (!strober_io.enable) begin
        pend_q <= 1'b0;
      end else if (last_d) begin
        pend_q     <= 1'b1;
        pend_val_q <= result_d;
        if (pend_q && !consume && (ovr_q != 8'hFF)) begin
          ovr_q <= ovr_q + 8'd1;
        end
      end else if (consume) begin
        pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (consume) begin
            x_q      <= pend_val_q;
            strobe_q <= 1'b1;
            tmr_q    <= PULSE_LOAD;
            state_q  <= PULSE;
          end
        end
        PULSE: begin
          if (tmr_q == '0) begin
            strobe_q <= 1'b0;
            tmr_q    <= GAP_LOAD;
            state_q  <= GAP;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        GAP: begin
          // Chaining straight into PULSE keeps back-to-back rises exactly MIN_GAP apart.
          if (tmr_q == '0) begin
            if (consume) begin
              x_q      <= pend_val_q;
              strobe_q <= 1'b1;
              tmr_q    <= PULSE_LOAD;
              state_q  <= PULSE;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        default: begin
          strobe_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign strober_io.x           = x_q;
  assign strober_io.strobe      = strobe_q;
  assign strober_io.overrun_cnt = ovr_q;
  assign strober_io.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_lpf_sample_strober.sv
// Scoreboard bench: two strober configurations share one randomized/directed sample stream
// and are compared against a block-average / minimum-spacing reference model.
module tb_lpf_sample_strober;

  localparam int DA = 4, SWA = 2, MGA = 3;
  localparam int DB = 0, SWB = 2, MGB = 6;

`ifdef LPF_STROBER_ROUND_EN
  localparam int EXP_ALT = 'hFFFF;
`else
  localparam int EXP_ALT = 'hFFFE;
`endif

  logic lb_clk = 1'b0;
  logic reset_n;
  always #5 lb_clk = ~lb_clk;

  lpf_sample_strober_if busA();
  lpf_sample_strober_if busB();

  lpf_sample_strober #(.DECIM_LOG2(DA), .STB_WIDTH(SWA), .MIN_GAP(MGA)) u_dutA (
    .lb_clk(lb_clk), .reset_n(reset_n), .strober_io(busA)
  );
  lpf_sample_strober #(.DECIM_LOG2(DB), .STB_WIDTH(SWB), .MIN_GAP(MGB)) u_dutB (
    .lb_clk(lb_clk), .reset_n(reset_n), .strober_io(busB)
  );

  typedef struct {
    int inst;
    int xv;
    int edgeNo;
    int ovr;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails = 0;
  int   cycle = 0;
  int   lastRstEdge = -1;

  int   blkSum[2], blkCnt[2], pendVal[2], lastRise[2], ovrM[2];
  bit   pendM[2];
  bit   prevStb[2];
  int   prevX[2], riseEdge[2], riseCnt[2];

  always @(posedge lb_clk) cycle <= cycle + 1;

  function automatic int cfgD(int i);
    return (i == 0) ? DA : DB;
  endfunction
  function automatic int cfgSW(int i);
    return (i == 0) ? SWA : SWB;
  endfunction
  function automatic int cfgMG(int i);
    return (i == 0) ? MGA : MGB;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference: average each full block with floor division; a held average is shown as soon
  // as MIN_GAP edges have passed since the previous showing; a replaced unshown average is an overrun.
  function automatic void stepModel(int i, int edgeNo, bit rstn, bit en, bit valid, int d);
    int   n, s, q;
    bit   consume, newRes;
    exp_t e;
    q = 0;
    if (!rstn) begin
      blkSum[i] = 0; blkCnt[i] = 0; pendM[i] = 0; lastRise[i] = -1000; ovrM[i] = 0;
      return;
    end
    n = 1 << cfgD(i);
    consume = en && pendM[i] && (edgeNo - lastRise[i] >= cfgMG(i));
    if (consume) begin
      e.inst = i; e.xv = pendVal[i]; e.edgeNo = edgeNo; e.ovr = ovrM[i];
      expQ.push_back(e);
      lastRise[i] = edgeNo;
    end
    newRes = 0;
    if (!en) begin
      blkSum[i] = 0; blkCnt[i] = 0;
    end else if (valid) begin
      blkSum[i] += d;
      blkCnt[i]++;
      if (blkCnt[i] == n) begin
        s = blkSum[i];
`ifdef LPF_STROBER_ROUND_EN
        s += n / 2;
`endif
        q = s / n;
        if ((s % n != 0) && (s < 0)) q--;
        newRes = 1;
        blkSum[i] = 0; blkCnt[i] = 0;
      end
    end
    if (!en) begin
      pendM[i] = 0;
    end else if (newRes) begin
      if (pendM[i] && !consume) ovrM[i] = (ovrM[i] < 255) ? ovrM[i] + 1 : 255;
      pendM[i] = 1;
      pendVal[i] = q;
    end else if (consume) begin
      pendM[i] = 0;
    end
  endfunction

  task automatic applyStimulus(input bit rstn, input bit en, input bit valid, input logic [15:0] d);
    int edgeNo;
    reset_n = rstn;
    busA.enable = en; busA.din_valid = valid; busA.din = d;
    busB.enable = en; busB.din_valid = valid; busB.din = d;
    edgeNo = cycle + 1;
    if (!rstn) lastRstEdge = edgeNo;
    stepModel(0, edgeNo, rstn, en, valid, int'($signed(d)));
    stepModel(1, edgeNo, rstn, en, valid, int'($signed(d)));
    @(posedge lb_clk);
    #3;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic block(input int n, input logic [15:0] d);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b1, 1'b1, d);
  endtask

  task automatic monitorInst(input int i, input bit stb, input logic signed [15:0] xs, input logic [7:0] ovr);
    exp_t e;
    bit   rise, fall;
    rise = stb && !prevStb[i];
    fall = !stb && prevStb[i];
    if (lastRstEdge != cycle) begin
      if (rise) begin
        riseCnt[i]++;
        riseEdge[i] = cycle;
        if (expQ.size() == 0) begin
          checkOutput($sformatf("unexpected strobe[%0d]", i), 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("strobe owner[%0d]", i), i, e.inst);
          checkOutput($sformatf("x at strobe[%0d]", i), int'(xs), e.xv);
          checkOutput($sformatf("strobe edge[%0d]", i), cycle, e.edgeNo);
          checkOutput($sformatf("overrun_cnt at strobe[%0d]", i), int'(ovr), e.ovr);
        end
      end else begin
        checkOutput($sformatf("x stable[%0d]", i), int'(xs), prevX[i]);
      end
      if (fall) checkOutput($sformatf("strobe width[%0d]", i), cycle - riseEdge[i], cfgSW(i));
    end
    prevStb[i] = stb;
    prevX[i] = int'(xs);
  endtask

  always @(negedge lb_clk) begin
    monitorInst(0, busA.strobe, busA.x, busA.overrun_cnt);
    monitorInst(1, busB.strobe, busB.x, busB.overrun_cnt);
  end

  initial begin
    int r0;
    for (int i = 0; i < 2; i++) begin
      blkSum[i] = 0; blkCnt[i] = 0; pendVal[i] = 0; lastRise[i] = -1000; ovrM[i] = 0;
      pendM[i] = 0; prevStb[i] = 0; prevX[i] = 0; riseEdge[i] = 0; riseCnt[i] = 0;
    end

    // Reset state
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("reset x A", int'($unsigned(busA.x)), 0);
    checkOutput("reset strobe A", int'(busA.strobe), 0);
    checkOutput("reset overrun A", int'(busA.overrun_cnt), 0);
    checkOutput("reset busy A", int'(busA.busy), 0);
    checkOutput("reset x B", int'($unsigned(busB.x)), 0);
    checkOutput("reset strobe B", int'(busB.strobe), 0);
    checkOutput("reset overrun B", int'(busB.overrun_cnt), 0);
    checkOutput("reset busy B", int'(busB.busy), 0);

    // First block: strobe timing relative to the 16th sample
    block(16, 16'h0100);
    checkOutput("t1 strobe after k", int'(busA.strobe), 0);
    idle(1);
    checkOutput("t1 strobe after k+1", int'(busA.strobe), 1);
    checkOutput("t1 x", int'($unsigned(busA.x)), 'h0100);
    idle(1);
    checkOutput("t1 strobe after k+2", int'(busA.strobe), 1);
    idle(1);
    checkOutput("t1 strobe after k+3", int'(busA.strobe), 0);
    checkOutput("t1 overrun A", int'(busA.overrun_cnt), 0);
    idle(6);

    // Negative average: truncation vs rounding
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFD);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000);
    end
    idle(4);
    checkOutput("t2 alternating x", int'($unsigned(busA.x)), EXP_ALT);

    // Full scale
    block(16, 16'h7FFF);
    idle(4);
    checkOutput("t3 full scale pos", int'($unsigned(busA.x)), 'h7FFF);
    block(16, 16'h8000);
    idle(4);
    checkOutput("t3 full scale neg", int'($unsigned(busA.x)), 'h8000);

    // Partial block discarded by enable=0
    r0 = riseCnt[0];
    block(7, 16'h1000);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 16'h1000);
    block(16, 16'h0010);
    idle(4);
    checkOutput("t5 strobe count", riseCnt[0] - r0, 1);
    checkOutput("t5 x", int'($unsigned(busA.x)), 'h0010);

    // Reset in the middle of a pulse
    block(16, 16'h1234);
    idle(1);
    checkOutput("t6 x before reset", int'($unsigned(busA.x)), 'h1234);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("t6 strobe", int'(busA.strobe), 0);
    checkOutput("t6 x", int'($unsigned(busA.x)), 0);
    checkOutput("t6 overrun", int'(busA.overrun_cnt), 0);
    checkOutput("t6 busy", int'(busA.busy), 0);
    r0 = riseCnt[0];
    block(16, 16'h0100);
    idle(4);
    checkOutput("t6 strobe after reset", riseCnt[0] - r0, 1);
    checkOutput("t6 x after reset", int'($unsigned(busA.x)), 'h0100);

    // Randomized traffic with occasional disables and resets
    for (int k = 0; k < 500; k++) begin
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 15) != 0,
                    $urandom_range(0, 3) != 0, 16'($urandom));
    end
    idle(10);

    // Backlog on the undecimated instance: overrun saturation
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int k = 0; k < 6 * 60; k++) applyStimulus(1'b1, 1'b1, 1'b1, 16'(k));
    checkOutput("t4 overrun saturated", int'(busB.overrun_cnt), 'hFF);
    idle(20);
    checkOutput("t4 overrun holds", int'(busB.overrun_cnt), 'hFF);

    checkOutput("final overrun A", int'(busA.overrun_cnt), ovrM[0]);
    checkOutput("final overrun B", int'(busB.overrun_cnt), ovrM[1]);
    checkOutput("final busy A", int'(busA.busy), 0);
    checkOutput("final busy B", int'(busB.busy), 0);
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
